// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared widths, state encoding and helpers for the memory responder
package mem_responder_pkg;
    localparam int MEM_DATA_BITS = 128;
    localparam int MASK_BITS = MEM_DATA_BITS / 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_RWAIT = 2'd2;
    localparam logic [1:0] S_RRESP = 2'd3;
    function automatic int beat_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_responder_array.sv
// mem_responder_array: single-port synchronous RAM with per-byte write enable and registered read
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_BITS = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [IDX_BITS-1:0]      i_addr,
    input  logic [MEM_DATA_BITS-1:0] i_wdata,
    input  logic [MASK_BITS-1:0]     i_mask,
    output logic [MEM_DATA_BITS-1:0] o_rdata
);
    logic [MEM_DATA_BITS-1:0] r_mem [DEPTH];

    // Byte-masked write; disabled bytes keep their previous contents
    always_ff @(posedge clk) begin
        if (i_en && i_we)
            for (int b = 0; b < MASK_BITS; b++)
                if (i_mask[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end

    // Registered read; the output register alone clears on reset so the response bus idles at zero
    always_ff @(posedge clk) begin
        if (reset) o_rdata <= '0;
        else if (i_en && !i_we) o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: burst memory target with byte-masked writes and fixed read latency
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS    = 28,
    parameter int DATA_CYCLES  = 4,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    output logic                     mem_req_ready,
    input  logic [ADDR_BITS-1:0]     mem_req_addr,
    input  logic                     mem_req_rw,
    input  logic                     mem_req_data_valid,
    output logic                     mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
    input  logic [MASK_BITS-1:0]     mem_req_data_mask,
    output logic                     mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0] mem_resp_data
);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int BEAT_BITS = beat_bits(DATA_CYCLES);
    localparam int LAT_BITS  = $clog2(READ_LATENCY);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(DATA_CYCLES - 1);
    localparam logic [LAT_BITS-1:0]  LAT_LOAD  = LAT_BITS'(READ_LATENCY - 1);
    localparam logic [LAT_BITS-1:0]  LAT_ONE   = LAT_BITS'(1);
    localparam logic [IDX_BITS-1:0]  LINE_MASK = ~IDX_BITS'(DATA_CYCLES - 1);

    logic [1:0]               r_state;
    logic [BEAT_BITS-1:0]     r_beat;
    logic [LAT_BITS-1:0]      r_lat;
    logic [IDX_BITS-1:0]      r_line;
    logic                     w_req_fire;
    logic                     w_data_fire;
    logic                     w_last_beat;
    logic                     w_rd_en;
    logic [BEAT_BITS-1:0]     w_rd_beat;
    logic [IDX_BITS-1:0]      w_idx;
    logic [MEM_DATA_BITS-1:0] w_rdata;
    logic                     w_unused_addr;

    // High address bits only alias onto the array and are otherwise ignored
    assign w_unused_addr = ^mem_req_addr;

    assign mem_req_ready      = !reset && r_state == S_IDLE;
    assign mem_req_data_ready = !reset && r_state == S_WDATA;
    assign mem_resp_valid     = !reset && r_state == S_RRESP;
    assign mem_resp_data      = reset ? '0 : w_rdata;

    assign w_req_fire  = mem_req_valid && mem_req_ready;
    assign w_data_fire = mem_req_data_valid && mem_req_data_ready;
    assign w_last_beat = r_beat == LAST_BEAT;

    // Each read is issued one cycle ahead of its beat: beat 0 from the last wait cycle, later beats while presenting the previous one
    assign w_rd_en   = !reset && ((r_state == S_RWAIT && r_lat == LAT_ONE) || (r_state == S_RRESP && !w_last_beat));
    assign w_rd_beat = r_state == S_RRESP ? r_beat + 1'b1 : '0;
    assign w_idx     = r_line | IDX_BITS'(w_data_fire ? r_beat : w_rd_beat);

    // Burst sequencing: latch the line on request, then count write beats or latency and read beats
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_lat   <= '0;
            r_line  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req_fire) begin
                    r_line  <= IDX_BITS'(mem_req_addr) & LINE_MASK;
                    r_lat   <= LAT_LOAD;
                    r_state <= mem_req_rw ? S_WDATA : S_RWAIT;
                end
                S_WDATA: if (w_data_fire) begin
                    r_beat  <= w_last_beat ? '0 : r_beat + 1'b1;
                    r_state <= w_last_beat ? S_IDLE : S_WDATA;
                end
                S_RWAIT: begin
                    r_lat   <= r_lat - 1'b1;
                    r_state <= r_lat == LAT_ONE ? S_RRESP : S_RWAIT;
                end
                default: begin
                    r_beat  <= w_last_beat ? '0 : r_beat + 1'b1;
                    r_state <= w_last_beat ? S_IDLE : S_RRESP;
                end
            endcase
        end
    end

    mem_responder_array #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_data_fire || w_rd_en),
        .i_we    (w_data_fire),
        .i_addr  (w_idx),
        .i_wdata (mem_req_data_bits),
        .i_mask  (mem_req_data_mask),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for burst writes, latency-timed burst reads, masking, aliasing and reset
module tb_mem_responder;
    import mem_responder_pkg::*;
    localparam int AB = 28;
    localparam int DC = 4;
    localparam int DEPTH = 4096;
    localparam int L = 4;

    logic                     clk = 0;
    logic                     reset = 1;
    logic                     mem_req_valid = 0;
    logic                     mem_req_ready;
    logic [AB-1:0]            mem_req_addr = '0;
    logic                     mem_req_rw = 0;
    logic                     mem_req_data_valid = 0;
    logic                     mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0] mem_req_data_bits = '0;
    logic [MASK_BITS-1:0]     mem_req_data_mask = '0;
    logic                     mem_resp_valid;
    logic [MEM_DATA_BITS-1:0] mem_resp_data;

    logic [MEM_DATA_BITS-1:0] model [DEPTH];
    logic [MEM_DATA_BITS-1:0] wd [DC];
    logic [MASK_BITS-1:0]     wm [DC];
    logic [MEM_DATA_BITS-1:0] exp_data [$];
    int                       exp_cyc [$];
    int                       cyc = 0;
    int                       compares = 0;
    int                       fails = 0;

    mem_responder #(
        .ADDR_BITS    (AB),
        .DATA_CYCLES  (DC),
        .DEPTH        (DEPTH),
        .READ_LATENCY (L)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rw         (mem_req_rw),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int line_of(input logic [AB-1:0] a);
        return int'(a % DEPTH) & ~(DC - 1);
    endfunction

    task automatic monitor();
        logic [MEM_DATA_BITS-1:0] d;
        int c;
        forever begin
            @(negedge clk);
            if (mem_resp_valid === 1'b1) begin
                compares++;
                if (exp_data.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat cycle %0d data %h want no beat", cyc, mem_resp_data);
                end else begin
                    d = exp_data.pop_front();
                    c = exp_cyc.pop_front();
                    if (mem_resp_data !== d) begin
                        fails++;
                        $display("FAIL beat_data cycle %0d got %h want %h", cyc, mem_resp_data, d);
                    end
                    compares++;
                    if (cyc !== c) begin
                        fails++;
                        $display("FAIL beat_cycle got %0d want %0d", cyc, c);
                    end
                end
            end
        end
    endtask

    task automatic send_req(input logic [AB-1:0] a, input logic rw, output int t);
        int n = 0;
        mem_req_valid = 1;
        mem_req_addr = a;
        mem_req_rw = rw;
        @(negedge clk);
        while (mem_req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mem_req_ready !== 1'b1) begin
            compares++;
            fails++;
            $display("FAIL req_timeout addr %h ready %b want 1", a, mem_req_ready);
        end
        t = cyc;
        @(posedge clk);
        #1;
        mem_req_valid = 0;
    endtask

    task automatic read_line(input logic [AB-1:0] a, output int t);
        send_req(a, 1'b0, t);
        for (int i = 0; i < DC; i++) begin
            exp_data.push_back(model[line_of(a) + i]);
            exp_cyc.push_back(t + L + i);
        end
    endtask

    task automatic write_line(input logic [AB-1:0] a, input int gap_after, input int gap,
                              input logic hold, input logic [AB-1:0] hold_addr, output int w);
        int t;
        int n;
        send_req(a, 1'b1, t);
        for (int i = 0; i < DC; i++) begin
            mem_req_data_valid = 1;
            mem_req_data_bits = wd[i];
            mem_req_data_mask = wm[i];
            n = 0;
            @(negedge clk);
            while (mem_req_data_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (mem_req_data_ready !== 1'b1) begin
                compares++;
                fails++;
                $display("FAIL data_timeout beat %0d ready %b want 1", i, mem_req_data_ready);
            end
            for (int b = 0; b < MASK_BITS; b++)
                if (wm[i][b]) model[line_of(a) + i][8*b +: 8] = wd[i][8*b +: 8];
            w = cyc;
            @(posedge clk);
            #1;
            mem_req_data_valid = 0;
            if (i == gap_after) begin
                mem_req_data_bits = '1;
                mem_req_data_mask = '1;
                if (hold) begin
                    mem_req_valid = 1;
                    mem_req_rw = 0;
                    mem_req_addr = hold_addr;
                end
                repeat (gap) begin
                    @(negedge clk);
                    compares++;
                    if (mem_req_ready !== 1'b0 || mem_req_data_ready !== 1'b1) begin
                        fails++;
                        $display("FAIL stall_ready got req_ready %b data_ready %b want 0 1", mem_req_ready, mem_req_data_ready);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        repeat (L + DC + 2) @(posedge clk);
        #1;
        compares++;
        if (exp_data.size() != 0) begin
            fails++;
            $display("FAIL %s_drain got %0d beats outstanding want 0", name, exp_data.size());
            exp_data.delete();
            exp_cyc.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compares++;
        if ({mem_req_ready, mem_req_data_ready, mem_resp_valid} !== 3'b000 || mem_resp_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %b%b%b data %h want 000 data 0", mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data);
        end
        @(posedge clk);
        #1;
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            compares++;
            if ({mem_req_ready, mem_req_data_ready, mem_resp_valid} !== 3'b100 || mem_resp_data !== '0) begin
                fails++;
                $display("FAIL idle_outputs cycle %0d got %b%b%b data %h want 100 data 0", cyc, mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int t;
        int w;
        mem_req_data_valid = 1;
        mem_req_data_bits = '1;
        repeat (2) begin
            @(negedge clk);
            compares++;
            if (mem_req_data_ready !== 1'b0) begin
                fails++;
                $display("FAIL idle_data_ready got %b want 0", mem_req_data_ready);
            end
        end
        @(posedge clk);
        #1;
        mem_req_data_valid = 0;
        for (int i = 0; i < DC; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, 24'($urandom), 8'(8'hA0 + i)};
            wm[i] = '1;
        end
        write_line(28'h10, -1, 0, 1'b0, '0, w);
        read_line(28'h10, t);
        while (cyc < t + L + DC - 1) @(negedge clk);
        compares++;
        if (mem_req_ready !== 1'b0 || mem_resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL last_beat_ready got ready %b valid %b want 0 1", mem_req_ready, mem_resp_valid);
        end
        @(negedge clk);
        compares++;
        if (mem_req_ready !== 1'b1 || mem_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL ready_return got ready %b valid %b want 1 0", mem_req_ready, mem_resp_valid);
        end
        drain("write_read");
    endtask

    task automatic test_mask();
        int t;
        int w;
        for (int i = 0; i < DC; i++) begin
            wd[i] = '1;
            wm[i] = '1;
        end
        write_line(28'h20, -1, 0, 1'b0, '0, w);
        for (int i = 0; i < DC; i++) begin
            wd[i] = '0;
            wm[i] = i == 1 ? MASK_BITS'(16'h000F) : '0;
        end
        write_line(28'h20, -1, 0, 1'b0, '0, w);
        compares++;
        if (model[line_of(28'h20) + 1] !== {{(MEM_DATA_BITS - 32){1'b1}}, 32'h0}) begin
            fails++;
            $display("FAIL mask_model got %h", model[line_of(28'h20) + 1]);
        end
        read_line(28'h20, t);
        drain("mask");
    endtask

    task automatic test_align_alias();
        int t;
        read_line(28'h13, t);
        drain("align");
        read_line(28'h10 + DEPTH, t);
        drain("alias");
    endtask

    task automatic test_back_to_back_stall();
        int t;
        int w;
        for (int i = 0; i < DC; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            wm[i] = '1;
        end
        write_line(28'h40, 1, 5, 1'b1, 28'h40, w);
        read_line(28'h40, t);
        compares++;
        if (t !== w + 1) begin
            fails++;
            $display("FAIL held_req_accept got cycle %0d want %0d", t, w + 1);
        end
        drain("stall");
    endtask

    task automatic test_reset_mid();
        int t;
        read_line(28'h10, t);
        while (cyc < t + L + 1) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1;
        exp_data.delete();
        exp_cyc.delete();
        @(negedge clk);
        compares++;
        if (mem_resp_valid !== 1'b0 || mem_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got valid %b ready %b want 0 0", mem_resp_valid, mem_req_ready);
        end
        @(posedge clk);
        #1;
        reset = 0;
        repeat (DC + 2) begin
            @(negedge clk);
            compares++;
            if (mem_resp_valid !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_valid got %b want 0", mem_resp_valid);
            end
        end
        @(posedge clk);
        #1;
        read_line(28'h10, t);
        drain("reset_mid");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_write_read();
        test_mask();
        test_align_alias();
        test_back_to_back_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
